// File: rtl/s3g_pkg.sv
// rtl/s3g_pkg.sv - shared S3G framing constants, error codes and receiver states
package s3g_pkg;

  localparam logic [7:0] S3G_START    = 8'hD5;
  localparam logic [7:0] S3G_CRC_POLY = 8'h8C;

  localparam logic [1:0] ERR_CRC      = 2'd0;
  localparam logic [1:0] ERR_LEN      = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
  localparam logic [1:0] ERR_OVERRUN  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LEN     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_CRC     = 2'd3
  } rx_state_e;

endpackage

// File: rtl/s3g_crc8.sv
// rtl/s3g_crc8.sv - combinational one-byte update of the reflected Maxim/1-Wire CRC-8
module s3g_crc8
  import s3g_pkg::*;
(
  input  logic [7:0] crc_in,
  input  logic [7:0] data_in,
  output logic [7:0] crc_next
);

  logic [7:0] c;

  // Fold the byte in, then shift out eight bits LSB-first through the reflected polynomial
  always_comb begin
    c = crc_in ^ data_in;
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ S3G_CRC_POLY) : (c >> 1);
    end
    crc_next = c;
  end

endmodule

// File: rtl/s3g_rx_dbuf.sv
// rtl/s3g_rx_dbuf.sv - S3G packet receiver with two-bank payload queue and error reporting
module s3g_rx_dbuf
  import s3g_pkg::*;
#(
  parameter int MAX_PAYLOAD    = 32,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int AW             = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    rx_data,
  input  logic          rx_done,
  output logic          packet_valid,
  output logic [7:0]    packet_len,
  input  logic          packet_ack,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic          packet_error,
  output logic [1:0]    error_code,
  output logic [15:0]   err_count,
  output logic          busy
);

  localparam int          DEPTH   = 2 ** (AW + 1);
  localparam logic [7:0]  MAX_LEN = 8'(MAX_PAYLOAD);
  localparam bit          TO_EN   = (TIMEOUT_CYCLES > 0);
  localparam logic [31:0] TO_LAST = TO_EN ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

  rx_state_e   state;
  logic [7:0]  len_q;
  logic [7:0]  idx_q;
  logic [7:0]  crc_q;
  logic [7:0]  crc_next;
  logic        drop_q;
  logic [31:0] idle_cnt;
  logic [1:0]  count;
  logic        wr_bank;
  logic        rd_bank;
  logic [7:0]  bank_len [2];
  logic [7:0]  mem [DEPTH];

  logic        timeout_hit;
  logic        do_commit;
  logic        do_pop;
  logic        err_fire;
  logic [1:0]  err_sel;

  s3g_crc8 u_crc (
    .crc_in   (crc_q),
    .data_in  (rx_data),
    .crc_next (crc_next)
  );

  assign timeout_hit  = TO_EN && (state != ST_IDLE) && !rx_done && (idle_cnt == TO_LAST);
  assign do_commit    = rx_done && (state == ST_CRC) && (rx_data == crc_q) && !drop_q;
  assign do_pop       = packet_ack && (count != 2'd0);
  assign packet_valid = (count != 2'd0);
  assign packet_len   = bank_len[rd_bank];
  assign busy         = (state != ST_IDLE);

  // Classify the frame failure, if any, caused by this cycle's byte or silence
  always_comb begin
    err_fire = 1'b0;
    err_sel  = ERR_CRC;
    if (timeout_hit) begin
      err_fire = 1'b1;
      err_sel  = ERR_TIMEOUT;
    end else if (rx_done) begin
      case (state)
        ST_LEN: begin
          if (rx_data > MAX_LEN) begin
            err_fire = 1'b1;
            err_sel  = ERR_LEN;
          end
        end
        ST_CRC: begin
          if (rx_data != crc_q) begin
            err_fire = 1'b1;
            err_sel  = ERR_CRC;
          end else if (drop_q) begin
            err_fire = 1'b1;
            err_sel  = ERR_OVERRUN;
          end
        end
        default: ;
      endcase
    end
  end

  // Frame parser, bank queue bookkeeping and error reporting
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= ST_IDLE;
      len_q        <= 8'd0;
      idx_q        <= 8'd0;
      crc_q        <= 8'd0;
      drop_q       <= 1'b0;
      idle_cnt     <= 32'd0;
      count        <= 2'd0;
      wr_bank      <= 1'b0;
      rd_bank      <= 1'b0;
      bank_len[0]  <= 8'd0;
      bank_len[1]  <= 8'd0;
      packet_error <= 1'b0;
      error_code   <= ERR_CRC;
      err_count    <= 16'd0;
    end else begin
      if (rx_done || state == ST_IDLE) idle_cnt <= 32'd0;
      else                             idle_cnt <= idle_cnt + 32'd1;

      if (timeout_hit) begin
        state <= ST_IDLE;
      end else if (rx_done) begin
        case (state)
          ST_IDLE: begin
            if (rx_data == S3G_START) begin
              state  <= ST_LEN;
              crc_q  <= 8'd0;
              drop_q <= (count == 2'd2);
            end
          end
          ST_LEN: begin
            len_q <= rx_data;
            idx_q <= 8'd0;
            if (rx_data > MAX_LEN)      state <= ST_IDLE;
            else if (rx_data == 8'd0)   state <= ST_CRC;
            else                        state <= ST_PAYLOAD;
          end
          ST_PAYLOAD: begin
            crc_q <= crc_next;
            idx_q <= idx_q + 8'd1;
            if (idx_q == len_q - 8'd1) state <= ST_CRC;
          end
          ST_CRC: begin
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end

      if (do_commit) begin
        bank_len[wr_bank] <= len_q;
        wr_bank           <= ~wr_bank;
      end
      if (do_pop) rd_bank <= ~rd_bank;
      if (do_commit && !do_pop)      count <= count + 2'd1;
      else if (!do_commit && do_pop) count <= count - 2'd1;

      packet_error <= err_fire;
      if (err_fire) begin
        error_code <= err_sel;
        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
      end
    end
  end

  // Payload RAM write port; bytes of an overrun frame are never stored
  always_ff @(posedge clk) begin
    if (rx_done && state == ST_PAYLOAD && !drop_q) begin
      mem[{wr_bank, idx_q[AW-1:0]}] <= rx_data;
    end
  end

  // Registered read of the head bank
  always_ff @(posedge clk) begin
    if (!rst) rd_data <= 8'd0;
    else      rd_data <= mem[{rd_bank, rd_addr}];
  end

endmodule

// File: tb/tb_s3g_rx_dbuf.sv
// tb/tb_s3g_rx_dbuf.sv - self-checking bench for s3g_rx_dbuf against a packet-level model
module tb_s3g_rx_dbuf;

  localparam int MAXP = 32;
  localparam int TO   = 50;

  typedef logic [7:0] byte_q_t [$];
  typedef struct {
    int         len;
    logic [7:0] b [32];
  } pkt_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_done = 1'b0;
  logic        packet_valid;
  logic [7:0]  packet_len;
  logic        packet_ack = 1'b0;
  logic [4:0]  rd_addr = 5'd0;
  logic [7:0]  rd_data;
  logic        packet_error;
  logic [1:0]  error_code;
  logic [15:0] err_count;
  logic        busy;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;
  bit rand_mode = 1'b0;
  byte_q_t sq;

  // model state
  pkt_t       m_q [$];
  logic [7:0] fb [$];
  bit         m_in_frame = 1'b0;
  bit         m_drop = 1'b0;
  int         m_idle = 0;
  bit         exp_err = 1'b0;
  logic [1:0] exp_code = 2'd0;
  int         exp_cnt = 0;
  logic [7:0] exp_rd = 8'd0;
  bit         rd_known = 1'b1;

  s3g_rx_dbuf #(.MAX_PAYLOAD(MAXP), .TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_data      (rx_data),
    .rx_done      (rx_done),
    .packet_valid (packet_valid),
    .packet_len   (packet_len),
    .packet_ack   (packet_ack),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .packet_error (packet_error),
    .error_code   (error_code),
    .err_count    (err_count),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Dallas/Maxim CRC-8: bit-serial, LSB first, reflected polynomial 0x8C
  function automatic logic [7:0] crc_ref(input byte_q_t d);
    logic [7:0] crc = 8'h00;
    foreach (d[k]) begin
      logic [7:0] v = d[k];
      for (int i = 0; i < 8; i++) begin
        if ((crc[0] ^ v[0]) == 1'b1) crc = (crc >> 1) ^ 8'h8C;
        else                         crc = crc >> 1;
        v = v >> 1;
      end
    end
    return crc;
  endfunction

  // Packet-level reference: frames, queue of accepted packets, error bookkeeping
  always @(posedge clk) begin : model
    bit         do_err;
    bit         commit_now;
    logic [1:0] code;
    pkt_t       cand;
    byte_q_t    pay;
    if (!rst) begin
      m_q.delete();
      fb.delete();
      m_in_frame = 1'b0;
      m_idle = 0;
      exp_err = 1'b0;
      exp_code = 2'd0;
      exp_cnt = 0;
      exp_rd = 8'd0;
      rd_known = 1'b1;
    end else begin
      do_err = 1'b0;
      commit_now = 1'b0;
      code = 2'd0;
      if (m_q.size() != 0 && int'(rd_addr) < m_q[0].len) begin
        exp_rd = m_q[0].b[rd_addr];
        rd_known = 1'b1;
      end else begin
        rd_known = 1'b0;
      end
      if (m_in_frame) begin
        if (rx_done) begin
          m_idle = 0;
          fb.push_back(rx_data);
          if (fb.size() == 1) begin
            if (rx_data > 8'(MAXP)) begin
              do_err = 1'b1; code = 2'd1; m_in_frame = 1'b0;
            end
          end else if (fb.size() == int'(fb[0]) + 2) begin
            cand.len = int'(fb[0]);
            pay.delete();
            for (int i = 0; i < cand.len; i++) begin
              cand.b[i] = fb[i+1];
              pay.push_back(fb[i+1]);
            end
            if (crc_ref(pay) != rx_data) begin
              do_err = 1'b1; code = 2'd0;
            end else if (m_drop) begin
              do_err = 1'b1; code = 2'd3;
            end else begin
              commit_now = 1'b1;
            end
            m_in_frame = 1'b0;
          end
        end else begin
          m_idle++;
          if (m_idle == TO) begin
            do_err = 1'b1; code = 2'd2; m_in_frame = 1'b0;
          end
        end
      end else if (rx_done && rx_data == 8'hD5) begin
        m_in_frame = 1'b1;
        fb.delete();
        m_drop = (m_q.size() == 2);
        m_idle = 0;
      end
      if (packet_ack && m_q.size() != 0) void'(m_q.pop_front());
      if (commit_now) m_q.push_back(cand);
      exp_err = do_err;
      if (do_err) begin
        exp_code = code;
        if (exp_cnt < 65535) exp_cnt++;
      end
    end
  end

  // Cycle-by-cycle comparison of the DUT against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("packet_valid", 32'(packet_valid), 32'(m_q.size() != 0));
      check("packet_error", 32'(packet_error), 32'(exp_err));
      check("error_code", 32'(error_code), 32'(exp_code));
      check("err_count", 32'(err_count), 32'(exp_cnt));
      check("busy", 32'(busy), 32'(m_in_frame));
      if (m_q.size() != 0) check("packet_len", 32'(packet_len), 32'(m_q[0].len));
      if (rd_known) check("rd_data", 32'(rd_data), 32'(exp_rd));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    rx_done = 1'b0;
    packet_ack = 1'b0;
    if (rand_mode) begin
      rd_addr = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 15) == 0) packet_ack = 1'b1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    tick();
    if (rand_mode && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
  endtask

  task automatic send_q(input byte_q_t q);
    foreach (q[i]) send_byte(q[i]);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_valid"}, 32'(packet_valid), 32'd0);
    check({tag, "_len"}, 32'(packet_len), 32'd0);
    check({tag, "_rd_data"}, 32'(rd_data), 32'd0);
    check({tag, "_error"}, 32'(packet_error), 32'd0);
    check({tag, "_code"}, 32'(error_code), 32'd0);
    check({tag, "_count"}, 32'(err_count), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic read_check(input string tag, input byte_q_t q);
    foreach (q[i]) begin
      rd_addr = 5'(i);
      tick();
      check(tag, 32'(rd_data), 32'(q[i]));
    end
  endtask

  task automatic rand_frame();
    int         kind;
    int         len;
    int         k;
    logic [7:0] b;
    byte_q_t    pay;
    kind = $urandom_range(0, 11);
    len = $urandom_range(0, MAXP);
    for (int i = 0; i < len; i++) pay.push_back(8'($urandom));
    case (kind)
      0: begin
        b = 8'($urandom);
        if (b == 8'hD5) b = 8'h00;
        send_byte(b);
      end
      1: begin
        send_byte(8'hD5);
        send_byte(8'($urandom_range(MAXP + 1, 255)));
      end
      2: begin
        send_byte(8'hD5);
        send_byte(8'(len));
        send_q(pay);
        send_byte(crc_ref(pay) ^ 8'($urandom_range(1, 255)));
      end
      3: begin
        send_byte(8'hD5);
        send_byte(8'(len));
        k = $urandom_range(0, len);
        for (int i = 0; i < k; i++) send_byte(pay[i]);
        repeat (TO + 5) tick();
      end
      4: begin
        send_byte(8'hD5);
        send_byte(8'd5);
        send_byte(8'hD5);
        rst = 1'b0;
        tick();
        rst = 1'b1;
      end
      default: begin
        send_byte(8'hD5);
        send_byte(8'(len));
        send_q(pay);
        send_byte(crc_ref(pay));
      end
    endcase
  endtask

  initial begin
    rst = 1'b0;
    tick();
    tick();
    check_zero_outputs("reset");
    rst = 1'b1;
    chk_en = 1'b1;

    sq = '{8'h01, 8'h02, 8'h03};
    check("model_crc_a", 32'(crc_ref(sq)), 32'hD8);
    sq = '{8'h1B, 8'h01, 8'h02};
    check("model_crc_b", 32'(crc_ref(sq)), 32'hF3);

    // good packet
    sq = '{8'hD5, 8'h03, 8'h01, 8'h02, 8'h03, 8'hD8};
    send_q(sq);
    check("good_valid", 32'(packet_valid), 32'd1);
    check("good_len", 32'(packet_len), 32'd3);
    check("good_errcnt", 32'(err_count), 32'd0);
    sq = '{8'h01, 8'h02, 8'h03};
    read_check("good_rd", sq);
    packet_ack = 1'b1;
    tick();
    check("good_popped", 32'(packet_valid), 32'd0);

    // CRC error
    sq = '{8'hD5, 8'h03, 8'h01, 8'h02, 8'h03, 8'hCC};
    send_q(sq);
    check("crc_pulse", 32'(packet_error), 32'd1);
    check("crc_code", 32'(error_code), 32'd0);
    check("crc_errcnt", 32'(err_count), 32'd1);
    check("crc_valid", 32'(packet_valid), 32'd0);
    tick();
    check("crc_pulse_end", 32'(packet_error), 32'd0);

    // leading junk
    sq = '{8'h0D, 8'hD5, 8'h03, 8'h00, 8'h01, 8'h02, 8'h78};
    send_q(sq);
    check("junk_valid", 32'(packet_valid), 32'd1);
    check("junk_errcnt", 32'(err_count), 32'd1);
    sq = '{8'h00, 8'h01, 8'h02};
    read_check("junk_rd", sq);
    packet_ack = 1'b1;
    tick();

    // overrun and queue order
    sq = '{8'hD5, 8'h03, 8'h01, 8'h02, 8'h03, 8'hD8,
           8'hD5, 8'h03, 8'h1B, 8'h01, 8'h02, 8'hF3,
           8'hD5, 8'h03, 8'h01, 8'h02, 8'h03, 8'hD8};
    send_q(sq);
    check("ovr_pulse", 32'(packet_error), 32'd1);
    check("ovr_code", 32'(error_code), 32'd3);
    check("ovr_errcnt", 32'(err_count), 32'd2);
    rd_addr = 5'd0;
    packet_ack = 1'b1;
    tick();
    check("ovr_valid_after_ack", 32'(packet_valid), 32'd1);
    sq = '{8'h1B, 8'h01, 8'h02};
    read_check("ovr_head", sq);

    // ack coincident with commit keeps one packet queued
    send_byte(8'hD5);
    send_byte(8'h00);
    packet_ack = 1'b1;
    send_byte(8'h00);
    check("same_cycle_valid", 32'(packet_valid), 32'd1);
    check("same_cycle_len", 32'(packet_len), 32'd0);
    packet_ack = 1'b1;
    tick();
    check("same_cycle_empty", 32'(packet_valid), 32'd0);

    // length error
    sq = '{8'hD5, 8'h21};
    send_q(sq);
    check("len_pulse", 32'(packet_error), 32'd1);
    check("len_code", 32'(error_code), 32'd1);
    check("len_busy", 32'(busy), 32'd0);

    // timeout
    sq = '{8'hD5, 8'h03, 8'h01};
    send_q(sq);
    repeat (TO - 1) tick();
    check("to_early_pulse", 32'(packet_error), 32'd0);
    check("to_early_busy", 32'(busy), 32'd1);
    tick();
    check("to_pulse", 32'(packet_error), 32'd1);
    check("to_code", 32'(error_code), 32'd2);
    check("to_busy", 32'(busy), 32'd0);

    // reset mid-frame
    sq = '{8'hD5, 8'h03, 8'h01};
    send_q(sq);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check_zero_outputs("midrst");
    tick();
    sq = '{8'hD5, 8'h03, 8'h01, 8'h02, 8'h03, 8'hD8};
    send_q(sq);
    check("midrst_accept", 32'(packet_valid), 32'd1);
    check("midrst_errcnt", 32'(err_count), 32'd0);
    packet_ack = 1'b1;
    tick();

    // randomized traffic
    rand_mode = 1'b1;
    repeat (200) rand_frame();
    rand_mode = 1'b0;
    repeat (5) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/s3g_rx_dbuf.md
# s3g_rx_dbuf

Parametrised S3G packet receiver with double-buffered payload storage. Sits between the UART byte receiver and the executor. It frames `0xD5, len, payload[len], crc8` packets and checks the Maxim/1-Wire CRC. Validated payloads are held in a two-bank RAM behind a valid/ack handshake, so the next packet can be received while the executor is still reading the previous one. It supersedes the fixed 16-byte, flat-port receiver. It adds configurable depth, an inter-byte timeout, overrun detection and an error counter.

## Interface
- `MAX_PAYLOAD`, 32: max payload bytes per packet; legal range 1..255.
- `TIMEOUT_CYCLES`, 100000: max clk cycles between bytes inside a frame; 0 disables the timeout.
- `AW`, `$clog2(MAX_PAYLOAD)`: read address width; derived, not overridden.
- `clk  in  1`: single clock, rising edge.
- `rst  in  1`: synchronous, active-low reset; 0 = reset.
- `rx_data  in  8`: received byte; valid when `rx_done` = 1.
- `rx_done  in  1`: one-cycle strobe per received byte.
- `packet_valid  out  1`: at least one validated packet is queued.
- `packet_len  out  8`: payload length of the head packet.
- `packet_ack  in  1`: one-cycle pulse that pops the head packet.
- `rd_addr  in  AW`: byte index into the head packet.
- `rd_data  out  8`: head-packet byte at `rd_addr`, registered.
- `packet_error  out  1`: one-cycle pulse on a frame failure.
- `error_code  out  2`: 0 = CRC, 1 = LEN, 2 = TIMEOUT, 3 = OVERRUN; holds the last error.
- `err_count  out  16`: saturating count of `packet_error` pulses.
- `busy  out  1`: frame in progress (state != IDLE).

## Operation
- FSM states: IDLE, LEN, PAYLOAD, CRC. Bytes are consumed only on `rx_done`.
- IDLE
  - `0xD5` → LEN; clear the CRC; latch `drop = (count == 2)`.
  - Any other byte is ignored silently, with no error.
- LEN
  - `len > MAX_PAYLOAD` → LEN error, go to IDLE.
  - `len == 0` → CRC.
  - Otherwise store `len`, clear the index, go to PAYLOAD.
- PAYLOAD
  - Write the byte to `{wr_bank, idx}` unless `drop` is set.
  - Update the CRC with the byte.
  - When `idx == len-1` → CRC.
- CRC state
  - Received byte != running CRC → CRC error.
  - Equal and `drop` → OVERRUN error.
  - Equal and not `drop` → commit: `bank_len[wr_bank] <= len`, `wr_bank` toggles, `count++`.
  - All three cases → IDLE.
- CRC algorithm: reflected poly `0x8C`, init `0x00`, over payload bytes only; the start and length bytes are excluded.
- Bank queue
  - `count` is 0..2, `rd_bank` is the head.
  - `packet_valid = (count != 0)`.
  - `packet_ack` with `count == 0` is ignored.
  - Ack pops: `rd_bank` toggles, `count--`.
  - Commit and ack in the same cycle: `count` unchanged, both pointers advance.
- Read path
  - `rd_data <= mem[{rd_bank, rd_addr}]` every cycle.
  - `rd_addr >= packet_len` returns stale bank contents; this is not an error.
- Timeout: in LEN, PAYLOAD or CRC, the idle counter increments each cycle without `rx_done` and clears on `rx_done`. Reaching `TIMEOUT_CYCLES` raises a TIMEOUT error and returns to IDLE.
- A `0xD5` inside a frame is ordinary data; there is no resynchronisation mid-frame.
- Every error
  - `packet_error` pulses, `error_code` updates, `err_count` saturates at `0xFFFF`.
  - Nothing is written to the queue; the partial bank content is discarded because `wr_bank` does not advance.

## Timing
- Reset (`rst` = 0 at a clk edge) puts every output at 0:
  - `packet_valid`, `packet_len`, `rd_data`, `packet_error`, `error_code`, `err_count`, `busy`.
  - FSM goes to IDLE; `count`, `wr_bank`, `rd_bank` go to 0.
- Reset mid-frame discards the frame and raises no error.
- `packet_valid` rises in the cycle after the clk edge that samples the CRC byte's `rx_done`.
- `packet_len` is valid in the same cycle as `packet_valid`.
- `packet_error` asserts in the cycle after the offending byte's edge. For TIMEOUT it asserts in the cycle after the counter reaches the limit.
- `rd_data` has 1-cycle latency from `rd_addr`. It reflects the new head from the cycle after the ack edge plus one.
- `packet_len` switches to the next bank's length in the cycle after the ack edge.
- Back-to-back `rx_done` on consecutive cycles is supported; throughput is 1 byte/clk.

## Structure
- Package `s3g_pkg`:
  - `S3G_START = 8'hD5` and `S3G_CRC_POLY = 8'h8C`.
  - Error-code localparams `ERR_CRC`, `ERR_LEN`, `ERR_TIMEOUT`, `ERR_OVERRUN`.
  - FSM state encoding.
  - The package is shared with `s3g_tx`.
- Sub-module `s3g_crc8`: combinational byte update, `crc_next = f(crc, byte)`. It is reused by the transmitter.
- Payload RAM: `2*MAX_PAYLOAD x 8`, inferred inside this module, synchronous read.

## Test plan
- **Good packet:** `D5 03 01 02 03 D8` → `packet_valid` = 1, `packet_len` = 3; `rd_addr` 0/1/2 gives `rd_data` `01`/`02`/`03`; `err_count` = 0.
- **CRC error:** `D5 03 01 02 03 CC` → `packet_error` pulse, `error_code` = 0, `err_count` = 1, `packet_valid` stays 0.
- **Leading junk:** `0D` then `D5 03 00 01 02 78` → `0D` is ignored; packet accepted with bytes `00 01 02`.
- **Overrun and queue order:**
  - Send `D5 03 01 02 03 D8`, then `D5 03 1B 01 02 F3`, with no ack.
  - A third good packet → OVERRUN (`error_code` = 3).
  - Ack → head is `1B 01 02`. Second ack → `packet_valid` = 0.
  - Ack in the same cycle as a commit keeps `count` = 1.
- **Length and timeout errors** (`MAX_PAYLOAD` = 32, `TIMEOUT_CYCLES` = 50):
  - `D5 21` → LEN error immediately.
  - `D5 03 01` then silence → TIMEOUT pulse 50 cycles after the last byte; `busy` drops.
- **Reset mid-frame:** `D5 03 01`, then `rst` = 0 for 1 cycle → all outputs 0, no error. The next `D5 03 01 02 03 D8` is accepted.
